core_mem_responder: RTL and testbench

Data-memory responder for the `Core` memory port. It consumes the core's `enable_M` / `addr_M` / `wr_data_M` requests and answers on `rd_data_M` / `ready_M` after a fixed, parameterised wait. It sits beside each `Core` instance in the cluster and replaces the always-ready memory stub used in core benches. It also provides a preload port, so program data can be loaded before `Start`.

---
 rtl/core_mem_pkg.sv | 21 ++
 rtl/core_mem_responder_if.sv | 23 ++
 rtl/core_mem_array.sv | 46 ++++
 rtl/core_mem_responder.sv | 149 ++++++++++++++
 tb/tb_core_mem_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared constants and types for the core data-memory responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package core_mem_pkg;

    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    // Statistics counters saturate at all-ones of this width.
    localparam int CNT_W  = 16;
    // Wait counter holds LATENCY-1, and LATENCY tops out at 15.
    localparam int WAIT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/core_mem_responder_if.sv
// Core memory-port bundle: request opcode/address/data out of the core, response back.
// Latency: n/a (wires only).
// Backpressure: ready_M low tells the core its request is still in flight.
interface core_mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [1:0]        enable_M;
    logic [ADDR_W-1:0] addr_M;
    logic [DATA_W-1:0] wr_data_M;
    logic [DATA_W-1:0] rd_data_M;
    logic              ready_M;

    modport master (
        output enable_M, addr_M, wr_data_M,
        input  rd_data_M, ready_M
    );

    modport slave (
        input  enable_M, addr_M, wr_data_M,
        output rd_data_M, ready_M
    );
endinterface

// File: rtl/core_mem_array.sv
// Single-port synchronous RAM with a registered read port that holds between reads.
// Latency: read data appears one edge after rd_en; write commits on the wr_en edge.
// Backpressure: none; caller guarantees at most one access per edge.
module core_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Read register only moves when a read completes, so writes never disturb it.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[addr];
        end
    end

    // Read register; reset clears it but the storage array keeps its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/core_mem_responder.sv
// Data-memory responder for the core memory port, with a preload path for program data.
// Latency: response LATENCY edges after acceptance; illegal opcode retires on the accept edge.
// Backpressure: ready_M low during BUSY; core inputs are ignored until ready_M returns high.
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    core_mem_responder_if.slave bus,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic              accept;
    logic              done;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // FSM next state: accept in IDLE, count down in BUSY, retire and bump statistics at zero.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        accept   = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable_M != MEM_IDLE) begin
                    accept = 1'b1;
                    if (bus.enable_M == MEM_ILL) begin
                        // Illegal opcode is swallowed without a BUSY period.
                        err_d = 1'b1;
                    end else begin
                        op_d    = bus.enable_M;
                        addr_d  = bus.addr_M;
                        wdata_d = bus.wr_data_M;
                        wait_d  = WAIT_LOAD;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (wait_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    if (op_q == MEM_RD && rd_cnt_q != CNT_MAX) begin
                        rd_cnt_d = rd_cnt_q + CNT_ONE;
                    end
                    if (op_q == MEM_WR && wr_cnt_q != CNT_MAX) begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory port mux: the latched request owns the port at completion, otherwise an idle preload may use it.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (!reset) begin
            if (done) begin
                mem_rd_en = (op_q == MEM_RD);
                mem_wr_en = (op_q == MEM_WR);
            end else if (state_q == ST_IDLE && !accept && init_we) begin
                mem_wr_en = 1'b1;
                mem_addr  = init_addr;
                mem_wdata = init_data;
            end
        end
    end

    // Control and statistics registers; reset aborts any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            op_q     <= MEM_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    core_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (mem_rd_en),
        .wr_en   (mem_wr_en),
        .addr    (mem_addr),
        .wr_data (mem_wdata),
        .rd_data (mem_rdata)
    );

    assign bus.ready_M   = (state_q == ST_IDLE);
    assign bus.rd_data_M = mem_rdata;
    assign err_illegal   = err_q;
    assign rd_cnt        = rd_cnt_q;
    assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1.
// Latency: expected responses queued at issue, checked when ready_M rises.
// Backpressure: stimulus waits (bounded) for ready_M before the next request.
module tb_core_mem_responder;
    import core_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0][1:0]  en;
    logic [1:0][7:0]  ad;
    logic [1:0][7:0]  wd;
    logic [1:0]       iwe;
    logic [1:0][7:0]  ia;
    logic [1:0][7:0]  idat;
    logic [1:0]       rdy;
    logic [1:0][7:0]  rdat;
    logic [1:0]       err;
    logic [1:0][15:0] rcnt;
    logic [1:0][15:0] wcnt;

    core_mem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
    core_mem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

    assign bus0.enable_M  = en[0];
    assign bus0.addr_M    = ad[0];
    assign bus0.wr_data_M = wd[0];
    assign rdy[0]         = bus0.ready_M;
    assign rdat[0]        = bus0.rd_data_M;
    assign bus1.enable_M  = en[1];
    assign bus1.addr_M    = ad[1];
    assign bus1.wr_data_M = wd[1];
    assign rdy[1]         = bus1.ready_M;
    assign rdat[1]        = bus1.rd_data_M;

    core_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst[0]), .bus(bus0),
        .init_we(iwe[0]), .init_addr(ia[0]), .init_data(idat[0]),
        .err_illegal(err[0]), .rd_cnt(rcnt[0]), .wr_cnt(wcnt[0])
    );

    core_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst[1]), .bus(bus1),
        .init_we(iwe[1]), .init_addr(ia[1]), .init_data(idat[1]),
        .err_illegal(err[1]), .rd_cnt(rcnt[1]), .wr_cnt(wcnt[1])
    );

    typedef struct {
        logic [7:0]  rd;
        logic [15:0] rc;
        logic [15:0] wc;
        int          busy;
        int          gap;
    } exp_t;

    exp_t exp_q [2][$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   busy_n [2] = '{0, 0};
    int   last_done [2] = '{0, 0};

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, got, want);
    endfunction

    function automatic void push(input int d, input logic [7:0] rd, input logic [15:0] rc,
                                 input logic [15:0] wc, input int busy, input int gap);
        exp_t e;
        e.rd = rd; e.rc = rc; e.wc = wc; e.busy = busy; e.gap = gap;
        exp_q[d].push_back(e);
    endfunction

    // Monitor: measure each BUSY window and score the response when ready_M rises.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                busy_n[d] = 0;
            end else if (!rdy[d]) begin
                busy_n[d]++;
            end else if (busy_n[d] != 0) begin
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("d%0d_unexpected_resp", d), exp_q[d].size(), 1);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("d%0d_busy_len", d), busy_n[d], e.busy);
                    chk($sformatf("d%0d_rd_data", d), rdat[d], e.rd);
                    chk($sformatf("d%0d_rd_cnt", d), rcnt[d], e.rc);
                    chk($sformatf("d%0d_wr_cnt", d), wcnt[d], e.wc);
                    if (e.gap > 0) chk($sformatf("d%0d_resp_gap", d), cyc - last_done[d], e.gap);
                end
                last_done[d] = cyc;
                busy_n[d] = 0;
            end
        end
    end

    task automatic issue(input int d, input logic [1:0] op, input logic [7:0] a, input logic [7:0] w);
        @(negedge clk);
        en[d] = op; ad[d] = a; wd[d] = w;
        @(negedge clk);
        en[d] = MEM_IDLE;
    endtask

    task automatic preload(input int d, input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        iwe[d] = 1'b1; ia[d] = a; idat[d] = v;
        @(negedge clk);
        iwe[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) return;
        end
        chk($sformatf("d%0d_wait_ready_timeout", d), rdy[d], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, ready=%b", rdy);
        $fatal(1);
    end

    initial begin
        rst = 2'b11; en = '0; ad = '0; wd = '0; iwe = '0; ia = '0; idat = '0;

        // Reset values on both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 2'b00;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_ready", d), rdy[d], 1);
            chk($sformatf("d%0d_rst_rd_data", d), rdat[d], 0);
            chk($sformatf("d%0d_rst_rd_cnt", d), rcnt[d], 0);
            chk($sformatf("d%0d_rst_wr_cnt", d), wcnt[d], 0);
            chk($sformatf("d%0d_rst_err", d), err[d], 0);
        end

        // Write then read at LATENCY=2; the write leaves rd_data_M at its reset value.
        push(0, 8'h00, 16'd0, 16'd1, 2, 0);
        issue(0, MEM_WR, 8'h10, 8'h5A);
        wait_idle(0);
        push(0, 8'h5A, 16'd1, 16'd1, 2, 0);
        issue(0, MEM_RD, 8'h10, 8'h00);
        wait_idle(0);

        // Preload then read; during that read's BUSY both addr_M and a preload change and must be ignored.
        preload(0, 8'hFF, 8'h33);
        push(0, 8'h33, 16'd2, 16'd1, 2, 0);
        issue(0, MEM_RD, 8'hFF, 8'h00);
        ad[0] = 8'h10; iwe[0] = 1'b1; ia[0] = 8'h10; idat[0] = 8'hEE;
        @(negedge clk);
        iwe[0] = 1'b0;
        wait_idle(0);
        push(0, 8'h5A, 16'd3, 16'd1, 2, 0);
        issue(0, MEM_RD, 8'h10, 8'h00);
        wait_idle(0);

        // Illegal opcode: sticky error, no BUSY period, no memory change.
        @(negedge clk);
        en[0] = MEM_ILL; ad[0] = 8'h10; wd[0] = 8'h99;
        @(posedge clk);
        #1;
        chk("ill_ready_high", rdy[0], 1);
        chk("ill_err_set", err[0], 1);
        @(negedge clk);
        en[0] = MEM_IDLE;
        @(negedge clk);
        chk("ill_err_sticky", err[0], 1);
        chk("ill_ready_idle", rdy[0], 1);
        push(0, 8'h5A, 16'd4, 16'd1, 2, 0);
        issue(0, MEM_RD, 8'h10, 8'h00);
        wait_idle(0);

        // Back-to-back reads at LATENCY=1: completions two cycles apart.
        preload(1, 8'h00, 8'hA0);
        preload(1, 8'h01, 8'hA1);
        push(1, 8'hA0, 16'd1, 16'd0, 1, 0);
        push(1, 8'hA1, 16'd2, 16'd0, 1, 2);
        @(negedge clk);
        en[1] = MEM_RD; ad[1] = 8'h00;
        @(negedge clk);
        ad[1] = 8'h01;
        @(negedge clk);
        @(negedge clk);
        en[1] = MEM_IDLE;
        wait_idle(1);

        // Reset in the middle of a write: write aborted, counters and flags cleared.
        preload(0, 8'h20, 8'h11);
        issue(0, MEM_WR, 8'h20, 8'h77);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("rstw_ready", rdy[0], 1);
        chk("rstw_wr_cnt", wcnt[0], 0);
        chk("rstw_rd_cnt", rcnt[0], 0);
        chk("rstw_rd_data", rdat[0], 0);
        chk("rstw_err", err[0], 0);
        push(0, 8'h11, 16'd1, 16'd0, 2, 0);
        issue(0, MEM_RD, 8'h20, 8'h00);
        wait_idle(0);

        // Read counter saturation from 0xFFFE.
        @(negedge clk);
        force dut0.rd_cnt_q = 16'hFFFE;
        #1;
        release dut0.rd_cnt_q;
        for (int i = 0; i < 3; i++) begin
            push(0, 8'h11, 16'hFFFF, 16'd0, 2, 0);
            issue(0, MEM_RD, 8'h20, 8'h00);
            wait_idle(0);
        end

        // Drain: every queued response must have been observed.
        for (int i = 0; i < 20 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) begin
            @(negedge clk);
        end
        chk("d0_pending_resps", exp_q[0].size(), 0);
        chk("d1_pending_resps", exp_q[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
